// File: rtl/cam_pkg.sv
// Shared constants and types for the content-addressable memory array.
package cam_pkg;

  localparam int CAM_WIDTH      = 32;
  localparam int CAM_ADDR_WIDTH = 5;

  // Architectural view of one entry: a valid flag plus the stored word.
  typedef struct packed {
    logic                 valid;
    logic [CAM_WIDTH-1:0] word;
  } cam_entry_t;

endpackage

// File: rtl/cam_entry.sv
// One CAM entry: storage, write port and a combinational match output.
// The match compares against the currently stored (pre-write) contents,
// so a same-cycle write is invisible to a concurrent search.
module cam_entry
  import cam_pkg::*;
#(
  parameter int WIDTH = CAM_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             write_enable_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             search_enable_i,
  input  logic [WIDTH-1:0] search_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] word_o,
  output logic             match_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_q,  word_d;

  // Next-state: a write sets the valid bit and captures the word.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (write_enable_i) begin
      valid_d = 1'b1;
      word_d  = write_data_i;
    end
  end

  // Entry storage, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign valid_o = valid_q;
  assign word_o  = word_q;
  assign match_o = search_enable_i & valid_q & (word_q == search_data_i);

endmodule

// File: rtl/cam_array.sv
// CAM array: DEPTH entries with a lowest-index read mux, a lowest-index
// priority encoder for search hits, and registered read/search results.
module cam_array
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DEPTH-1:0]      write_enable_i,
  input  logic [DEPTH-1:0]      read_enable_i,
  input  logic [DEPTH-1:0]      search_enable_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic [WIDTH-1:0]      search_data_i,
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  search_valid_o,
  output logic                  search_found_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_match;
  logic [WIDTH-1:0] entry_word [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    cam_entry #(.WIDTH(WIDTH)) u_entry (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .write_enable_i  (write_enable_i[g]),
      .write_data_i    (write_data_i),
      .search_enable_i (search_enable_i[g]),
      .search_data_i   (search_data_i),
      .valid_o         (entry_valid[g]),
      .word_o          (entry_word[g]),
      .match_o         (entry_match[g])
    );
  end

  logic                  read_valid_q;
  logic [WIDTH-1:0]      read_value_q, read_value_d;
  logic                  search_valid_q;
  logic                  search_found_q, search_found_d;
  logic [ADDR_WIDTH-1:0] search_index_q, search_index_d;

  // Read mux: lowest asserted strobe wins; an invalid entry reads as zero.
  // Scanning downward lets the lowest index overwrite higher ones.
  always_comb begin
    read_value_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (read_enable_i[i]) begin
        read_value_d = entry_valid[i] ? entry_word[i] : '0;
      end
    end
  end

  // Priority encoder: lowest matching index, zero on a miss.
  always_comb begin
    search_found_d = |entry_match;
    search_index_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entry_match[i]) begin
        search_index_d = i[ADDR_WIDTH-1:0];
      end
    end
  end

  // Output registers: valid flags pulse per request, data holds when idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      read_valid_q   <= 1'b0;
      read_value_q   <= '0;
      search_valid_q <= 1'b0;
      search_found_q <= 1'b0;
      search_index_q <= '0;
    end else begin
      read_valid_q   <= |read_enable_i;
      search_valid_q <= |search_enable_i;
      if (|read_enable_i) begin
        read_value_q <= read_value_d;
      end
      if (|search_enable_i) begin
        search_found_q <= search_found_d;
        search_index_q <= search_index_d;
      end
    end
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_valid_o = search_valid_q;
  assign search_found_o = search_found_q;
  assign search_index_o = search_index_q;

endmodule

// File: doc/cam_array.md
CAM_ARRAY -- requirements
Module: cam_array

Interface
REQ-001 Parameter WIDTH, default 32: bits per stored word.
REQ-002 Parameter ADDR_WIDTH, default 5: entry index width.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH: number of entries.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 reset_i  input  1  reset, asynchronous, active-high.
REQ-006 write_enable_i  input  DEPTH  per-entry write strobes, one-hot or zero, from the CAM decoder.
REQ-007 read_enable_i  input  DEPTH  per-entry read strobes, one-hot or zero, from the CAM decoder.
REQ-008 search_enable_i  input  DEPTH  per-entry search qualifiers from the CAM decoder.
REQ-009 write_data_i  input  WIDTH  word stored on write.
REQ-010 search_data_i  input  WIDTH  key compared on search.
REQ-011 read_valid_o  output  1  registered read result valid.
REQ-012 read_value_o  output  WIDTH  registered read word.
REQ-013 search_valid_o  output  1  registered search result valid.
REQ-014 search_found_o  output  1  registered hit flag.
REQ-015 search_index_o  output  ADDR_WIDTH  registered lowest matching index.

Function
REQ-016 Each entry SHALL hold a WIDTH-bit word plus a valid bit.
REQ-017 A cycle with write_enable_i[k]=1 SHALL store write_data_i into entry k and set its valid bit at the clock edge.
REQ-018 A cycle with any read_enable_i bit set SHALL, one cycle later, assert read_valid_o for exactly one cycle with read_value_o = word of the lowest asserted index.
REQ-019 Reading an entry whose valid bit is clear SHALL return read_valid_o=1, read_value_o=0.
REQ-020 With read_enable_i all zero, read_valid_o SHALL be 0 next cycle and read_value_o SHALL hold its last value.
REQ-021 A search is requested when any search_enable_i bit is set; one cycle later search_valid_o SHALL pulse for one cycle.
REQ-022 Entry k matches when search_enable_i[k]=1, valid[k]=1 and word[k]==search_data_i (full-width equality).
REQ-023 search_found_o SHALL equal OR of all matches; search_index_o SHALL be the lowest matching index, or 0 on miss.
REQ-024 Without a search request, search_valid_o SHALL be 0 and search_found_o/search_index_o SHALL hold.
REQ-025 Read or search in the same cycle as a write to the same entry SHALL observe the pre-write contents and valid bit.
REQ-026 Read, write and search SHALL be accepted concurrently every cycle; no stalls, no backpressure.
REQ-027 Multiple write_enable_i bits set SHALL write all flagged entries with write_data_i (defined, not expected).

Reset
REQ-028 Assertion of reset_i SHALL immediately clear all valid bits, all stored words, read_valid_o, read_value_o, search_valid_o, search_found_o and search_index_o to 0.
REQ-029 Writes, reads and searches in flight when reset asserts SHALL be discarded; no output pulse follows reset deassertion.

Structure
REQ-030 Package cam_pkg SHALL hold default WIDTH/ADDR_WIDTH constants and the entry struct type (valid, word).
REQ-031 Sub-module cam_entry SHALL implement one entry: storage, write, and match output; cam_array SHALL instantiate DEPTH copies plus read mux, priority encoder and output registers.

Verification
REQ-032 Reset, write 0xDEADBEEF to entry 3, read entry 3 next cycle -> read_valid_o=1, read_value_o=0xDEADBEEF one cycle after read.
REQ-033 Write 0xA5 to entries 7 and 2, search 0xA5 with all search enables -> search_found_o=1, search_index_o=2; search 0x5A -> found=0, index=0.
REQ-034 Search 0xA5 with search_enable_i bit 2 cleared -> index=7.
REQ-035 Same cycle: write 0x11 to entry 4 (previously 0x22), read entry 4, search 0x11 -> read_value_o=0x22, search_found_o=0; following search 0x11 -> found=1, index=4.
REQ-036 Read never-written entry 9 -> read_valid_o=1, read_value_o=0; assert reset_i mid-search -> all outputs 0 immediately, no search_valid_o pulse after release.
REQ-037 Randomised concurrent read/write/search against a reference model for 10000 cycles -> zero mismatches.
